fpu_op_issue: RTL and testbench

Opcode/operand issue queue that sits directly upstream of the FPU microcode sequencer. Accepts floating-point operations from the integer unit, filters out non-FP opcodes, buffers up to DEPTH operations with their operands, and presents the head entry to the sequencer as `nx_opcode`/`nx_fpop_valid`. An entry retires when the sequencer samples it at an opcode-look point. `fpkill` flushes the queue; `fpuhold` freezes it.

---
 rtl/fpu_op_issue_pkg.sv | 37 +++
 rtl/fpu_issue_fifo.sv | 58 +++++
 rtl/fpu_op_issue.sv | 75 +++++++
 tb/tb_fpu_op_issue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_op_issue_pkg.sv
// fpu_op_issue_pkg: shared FPU opcode constants and the FP-opcode classifier.
// Used by the issue queue and the sequencer map decode so both agree on what is an FP op.
package fpu_op_issue_pkg;

    localparam logic [7:0] OP_FADD  = 8'h62;
    localparam logic [7:0] OP_DADD  = 8'h63;
    localparam logic [7:0] OP_FSUB  = 8'h66;
    localparam logic [7:0] OP_DSUB  = 8'h67;
    localparam logic [7:0] OP_FMUL  = 8'h6a;
    localparam logic [7:0] OP_DMUL  = 8'h6b;
    localparam logic [7:0] OP_FDIV  = 8'h6e;
    localparam logic [7:0] OP_DDIV  = 8'h6f;
    localparam logic [7:0] OP_FREM  = 8'h72;
    localparam logic [7:0] OP_DREM  = 8'h73;
    localparam logic [7:0] OP_I2F   = 8'h86;
    localparam logic [7:0] OP_I2D   = 8'h87;
    localparam logic [7:0] OP_L2F   = 8'h89;
    localparam logic [7:0] OP_L2D   = 8'h8a;
    localparam logic [7:0] OP_F2I   = 8'h8b;
    localparam logic [7:0] OP_F2L   = 8'h8c;
    localparam logic [7:0] OP_F2D   = 8'h8d;
    localparam logic [7:0] OP_D2I   = 8'h8e;
    localparam logic [7:0] OP_D2L   = 8'h8f;
    localparam logic [7:0] OP_D2F   = 8'h90;
    localparam logic [7:0] OP_FCMPL = 8'h95;
    localparam logic [7:0] OP_FCMPG = 8'h96;
    localparam logic [7:0] OP_DCMPL = 8'h97;
    localparam logic [7:0] OP_DCMPG = 8'h98;

    function automatic logic is_fp_op(input logic [7:0] op);
        return op inside {OP_FADD, OP_DADD, OP_FSUB, OP_DSUB, OP_FMUL, OP_DMUL,
                          OP_FDIV, OP_DDIV, OP_FREM, OP_DREM, OP_I2F, OP_I2D,
                          OP_L2F, OP_L2D, OP_F2I, OP_F2L, OP_F2D, OP_D2I,
                          OP_D2L, OP_D2F, OP_FCMPL, OP_FCMPG, OP_DCMPL, OP_DCMPG};
    endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: DEPTH-entry opcode+operand FIFO with head/tail pointers and occupancy count.
// Ports: clk, reset_l (async active-low); push_i/pop_i/flush_i controls (pre-qualified by the
// caller); wr_op_i/wr_a_i/wr_b_i tail write data; rd_op_o/rd_a_o/rd_b_o raw head entry
// (unmasked); count_o occupancy.
module fpu_issue_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [7:0]        wr_op_i,
    input  logic [DATA_W-1:0] wr_a_i,
    input  logic [DATA_W-1:0] wr_b_i,
    output logic [7:0]        rd_op_o,
    output logic [DATA_W-1:0] rd_a_o,
    output logic [DATA_W-1:0] rd_b_o,
    output logic [2:0]        count_o
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int EW = 8 + 2 * DATA_W;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [2:0]    count_q, count_d;

    always_comb begin
        head_d  = flush_i ? '0 : pop_i  ? (head_q == LAST ? '0 : head_q + PW'(1)) : head_q;
        tail_d  = flush_i ? '0 : push_i ? (tail_q == LAST ? '0 : tail_q + PW'(1)) : tail_q;
        count_d = flush_i ? '0 : count_q + {2'b00, push_i} - {2'b00, pop_i};
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the top masks the head whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[tail_q] <= {wr_op_i, wr_a_i, wr_b_i};
    end

    assign {rd_op_o, rd_a_o, rd_b_o} = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fpu_op_issue.sv
// fpu_op_issue: FP opcode/operand issue queue feeding the FPU microcode sequencer.
// Inputs: clk, reset_l (async active-low), iu_fpop/iu_fpop_valid/iu_op_a/iu_op_b offer from
// the integer unit, nx_opcode_look (sequencer sample), fpuhold (freeze), fpkill (flush).
// Outputs: fpu_rdy (accept this cycle), iu_fpop_err (non-FP drop pulse), nx_opcode/
// nx_fpop_valid/nx_op_a/nx_op_b head entry (zero when empty), fq_count occupancy.
module fpu_op_issue
    import fpu_op_issue_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [7:0]        iu_fpop,
    input  logic              iu_fpop_valid,
    input  logic [DATA_W-1:0] iu_op_a,
    input  logic [DATA_W-1:0] iu_op_b,
    output logic              fpu_rdy,
    output logic              iu_fpop_err,
    output logic [7:0]        nx_opcode,
    output logic              nx_fpop_valid,
    output logic [DATA_W-1:0] nx_op_a,
    output logic [DATA_W-1:0] nx_op_b,
    input  logic              nx_opcode_look,
    input  logic              fpuhold,
    input  logic              fpkill,
    output logic [2:0]        fq_count
);

    logic              full, pop, offer, push, err_d, err_q;
    logic [7:0]        head_op;
    logic [DATA_W-1:0] head_a, head_b;

    always_comb begin
        full          = fq_count == 3'(DEPTH);
        nx_fpop_valid = fq_count != 3'd0;
        pop           = nx_fpop_valid && nx_opcode_look && !fpuhold && !fpkill;
        // A full queue frees a slot only when the head retires in the same cycle.
        fpu_rdy       = !full || pop;
        offer         = iu_fpop_valid && fpu_rdy && !fpkill && !fpuhold;
        push          = offer && is_fp_op(iu_fpop);
        err_d         = offer && !is_fp_op(iu_fpop);
        nx_opcode     = nx_fpop_valid ? head_op : '0;
        nx_op_a       = nx_fpop_valid ? head_a : '0;
        nx_op_b       = nx_fpop_valid ? head_b : '0;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign iu_fpop_err = err_q;

    fpu_issue_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk    (clk),
        .reset_l(reset_l),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(fpkill),
        .wr_op_i(iu_fpop),
        .wr_a_i (iu_op_a),
        .wr_b_i (iu_op_b),
        .rd_op_o(head_op),
        .rd_a_o (head_a),
        .rd_b_o (head_b),
        .count_o(fq_count)
    );

endmodule

// File: tb/tb_fpu_op_issue.sv
// tb_fpu_op_issue: directed self-checking bench for fpu_op_issue (DEPTH=2, DATA_W=64).
module tb_fpu_op_issue;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic [7:0]  iu_fpop = '0;
    logic        iu_fpop_valid = 1'b0;
    logic [63:0] iu_op_a = '0, iu_op_b = '0;
    logic        fpu_rdy, iu_fpop_err, nx_fpop_valid;
    logic [7:0]  nx_opcode;
    logic [63:0] nx_op_a, nx_op_b;
    logic        nx_opcode_look = 1'b0, fpuhold = 1'b0, fpkill = 1'b0;
    logic [2:0]  fq_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_op_issue #(.DEPTH(2), .DATA_W(64)) dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .iu_fpop       (iu_fpop),
        .iu_fpop_valid (iu_fpop_valid),
        .iu_op_a       (iu_op_a),
        .iu_op_b       (iu_op_b),
        .fpu_rdy       (fpu_rdy),
        .iu_fpop_err   (iu_fpop_err),
        .nx_opcode     (nx_opcode),
        .nx_fpop_valid (nx_fpop_valid),
        .nx_op_a       (nx_op_a),
        .nx_op_b       (nx_op_b),
        .nx_opcode_look(nx_opcode_look),
        .fpuhold       (fpuhold),
        .fpkill        (fpkill),
        .fq_count      (fq_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        iu_fpop_valid = 1'b1;
        iu_fpop = op;
        iu_op_a = a;
        iu_op_b = b;
    endtask

    task automatic idle();
        iu_fpop_valid = 1'b0;
        nx_opcode_look = 1'b0;
        fpuhold = 1'b0;
        fpkill = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, 64'(fpu_rdy), 64'd1);
        chk({tag, "_err"}, 64'(iu_fpop_err), 64'd0);
        chk({tag, "_op"}, 64'(nx_opcode), 64'h00);
        chk({tag, "_vld"}, 64'(nx_fpop_valid), 64'd0);
        chk({tag, "_a"}, nx_op_a, 64'd0);
        chk({tag, "_b"}, nx_op_b, 64'd0);
        chk({tag, "_cnt"}, 64'(fq_count), 64'd0);
    endtask

    initial begin
        #12;
        chk_reset("rst");
        @(negedge clk);
        reset_l = 1'b1;

        // single push then retire
        offer(8'h62, 64'h3f800000, 64'h40000000);
        cyc();
        idle();
        chk("t1_vld", 64'(nx_fpop_valid), 64'd1);
        chk("t1_op", 64'(nx_opcode), 64'h62);
        chk("t1_cnt", 64'(fq_count), 64'd1);
        chk("t1_a", nx_op_a, 64'h3f800000);
        chk("t1_b", nx_op_b, 64'h40000000);
        nx_opcode_look = 1'b1;
        cyc();
        idle();
        chk("t1_empty_cnt", 64'(fq_count), 64'd0);
        chk("t1_empty_op", 64'(nx_opcode), 64'h00);
        chk("t1_empty_vld", 64'(nx_fpop_valid), 64'd0);
        chk("t1_empty_a", nx_op_a, 64'd0);

        // fill, blocked offer, push-with-pop while full, pointer wrap
        offer(8'h6b, 64'd1, 64'd2);
        cyc();
        offer(8'h6f, 64'd3, 64'd4);
        cyc();
        offer(8'h62, 64'd5, 64'd6);
        #1;
        chk("t2_full_cnt", 64'(fq_count), 64'd2);
        chk("t2_full_rdy", 64'(fpu_rdy), 64'd0);
        chk("t2_head", 64'(nx_opcode), 64'h6b);
        chk("t2_head_a", nx_op_a, 64'd1);
        cyc();
        chk("t2_ign_cnt", 64'(fq_count), 64'd2);
        chk("t2_ign_head", 64'(nx_opcode), 64'h6b);
        chk("t2_ign_err", 64'(iu_fpop_err), 64'd0);
        nx_opcode_look = 1'b1;
        #1;
        chk("t2_rdy_pop", 64'(fpu_rdy), 64'd1);
        cyc();
        iu_fpop_valid = 1'b0;
        chk("t2_pp_cnt", 64'(fq_count), 64'd2);
        chk("t2_pp_head", 64'(nx_opcode), 64'h6f);
        chk("t2_pp_b", nx_op_b, 64'd4);
        cyc();
        chk("t2_wrap_head", 64'(nx_opcode), 64'h62);
        chk("t2_wrap_a", nx_op_a, 64'd5);
        chk("t2_wrap_cnt", 64'(fq_count), 64'd1);
        cyc();
        idle();
        chk("t2_drain_cnt", 64'(fq_count), 64'd0);

        // non-FP opcode dropped with a one-cycle error pulse
        offer(8'h60, 64'd7, 64'd8);
        cyc();
        idle();
        chk("t3_err", 64'(iu_fpop_err), 64'd1);
        chk("t3_cnt", 64'(fq_count), 64'd0);
        chk("t3_vld", 64'(nx_fpop_valid), 64'd0);
        cyc();
        chk("t3_err_clr", 64'(iu_fpop_err), 64'd0);

        // kill dominates push and pop
        offer(8'h6a, 64'd10, 64'd11);
        cyc();
        offer(8'h72, 64'd12, 64'd13);
        cyc();
        chk("t4_pre_cnt", 64'(fq_count), 64'd2);
        offer(8'h66, 64'd14, 64'd15);
        nx_opcode_look = 1'b1;
        fpkill = 1'b1;
        cyc();
        idle();
        chk("t4_cnt", 64'(fq_count), 64'd0);
        chk("t4_vld", 64'(nx_fpop_valid), 64'd0);
        chk("t4_err", 64'(iu_fpop_err), 64'd0);
        chk("t4_op", 64'(nx_opcode), 64'h00);

        // hold freezes everything, release does pop+push together
        offer(8'h8d, 64'd20, 64'd21);
        cyc();
        offer(8'h86, 64'd22, 64'd23);
        nx_opcode_look = 1'b1;
        fpuhold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_hold_cnt", 64'(fq_count), 64'd1);
            chk("t5_hold_op", 64'(nx_opcode), 64'h8d);
            chk("t5_hold_a", nx_op_a, 64'd20);
            chk("t5_hold_err", 64'(iu_fpop_err), 64'd0);
        end
        fpuhold = 1'b0;
        cyc();
        idle();
        chk("t5_rel_cnt", 64'(fq_count), 64'd1);
        chk("t5_rel_op", 64'(nx_opcode), 64'h86);
        chk("t5_rel_a", nx_op_a, 64'd22);

        // asynchronous reset between edges
        nx_opcode_look = 1'b1;
        cyc();
        idle();
        offer(8'h95, 64'd30, 64'd31);
        cyc();
        offer(8'h98, 64'd32, 64'd33);
        cyc();
        idle();
        chk("t6_pre_cnt", 64'(fq_count), 64'd2);
        @(negedge clk);
        reset_l = 1'b0;
        #1;
        chk_reset("t6");
        @(negedge clk);
        reset_l = 1'b1;
        offer(8'h63, 64'd40, 64'd41);
        cyc();
        idle();
        chk("t6_post_cnt", 64'(fq_count), 64'd1);
        chk("t6_post_op", 64'(nx_opcode), 64'h63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1);
    end

endmodule
